bk_adder_pipe: RTL and testbench
================================

# bk_adder_pipe

Parametrised, pipelined Brent-Kung prefix adder with carry-in and valid/ready handshaking on both sides. It is the next generation of the team's fixed 12-bit combinational Brent-Kung adder. It keeps the interleaved operand bus and {carry, sum} result bus layout, and adds configurable width, configurable register depth and back-pressure. It sits between operand-producing datapath stages and result consumers that may stall.

## Interface
- `WIDTH`, 12: operand width in bits. Legal range 2..64.
- `STAGES`, 2: number of register stages. Legal range 1..4. Out-of-range values are a fatal elaboration error.
- `clk` input 1: sole clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `INPUTS` input 2*WIDTH: interleaved operands. `INPUTS[2i]` = a[i], `INPUTS[2i+1]` = b[i].
- `cin` input 1: carry-in.
- `in_valid` input 1: the operand beat is valid.
- `in_ready` output 1: the block accepts the beat this cycle.
- `OUTS` output WIDTH+1: `OUTS[WIDTH-1:0]` = sum, `OUTS[WIDTH]` = carry-out.
- `out_valid` output 1: `OUTS` holds a valid result.
- `out_ready` input 1: the consumer takes the result this cycle.
- `ovf` output 1: signed overflow. Present only with `BK_ADDER_OVERFLOW_EN`.

## Operation
- Result: {`OUTS[WIDTH]`, `OUTS[WIDTH-1:0]`} = a + b + cin, computed to full WIDTH+1 precision with no truncation.
- Logic levels:
  - L0: per-bit g = a&b, p = a^b. cin is folded in as g[-1].
  - L1: Brent-Kung up-sweep over ceil(log2(WIDTH+1)) levels.
  - L2: down-sweep.
  - L3: sum = p ^ carry, plus carry-out.
- Non-power-of-two WIDTH: pad internally with p=0, g=0. Padding must not affect the result.
- Register placement, cumulative by `STAGES`:
  - 1: after L3 only.
  - 2: also after L1.
  - 3: also after L0.
  - 4: also after L2.
- Each stage holds a data register plus a valid bit.
- Per-stage handshake, bubble-collapsing:
  - Stage k loads when it is empty, or when its content moves on in the same cycle.
  - `in_ready` = stage-1 load condition.
  - Last-stage content moves when `out_valid & out_ready`.
- Transfer rules:
  - Input is accepted only on `in_valid & in_ready`.
  - `OUTS` and `ovf` hold stable while `out_valid & ~out_ready`.
  - A single result is never duplicated or dropped.
  - Accepted beats leave in order.
- Simultaneous accept and drain at the full last stage: the new data replaces the old in that cycle, so there is no lost cycle.
- Reset:
  - All valid bits clear and all data registers clear to 0.
  - `out_valid`=0, `OUTS`=0, `ovf`=0.
  - `in_ready`=0 while `rst` is high, then 1 in the first cycle after release.
  - Reset mid-operation discards all in-flight beats. No partial result appears.

## Timing
- Latency: `STAGES` cycles from accept edge to `out_valid` high, when there is no back-pressure.
- Throughput: one result per cycle while `out_ready`=1.
- Capacity: `STAGES` beats in flight. When the pipe is full and `out_ready`=0, `in_ready`=0.
- `in_ready` depends combinationally on `out_ready` and the stage valid bits only. It never depends on `in_valid`.
- No other combinational path from inputs to outputs. `OUTS`, `out_valid` and `ovf` are register outputs.
- Critical path at `STAGES`=1 is the full L0..L3 depth, about 2*log2(WIDTH) prefix cells.

## Configuration
- `BK_ADDER_OVERFLOW_EN` defined:
  - Adds output `ovf` = carry into the MSB XOR carry-out of the MSB.
  - `ovf` is registered alongside `OUTS` in the last stage and resets to 0.
  - MSB carry-in is carried through the pipeline registers.
- `BK_ADDER_OVERFLOW_EN` undefined:
  - Port `ovf` and its logic are absent.
  - All other behaviour is identical.

## Test plan
- `WIDTH`=12, `STAGES`=2: a=0xFFF, b=0x001, cin=0 → after 2 cycles `out_valid`=1 and `OUTS`=0x1000.
- `WIDTH`=12, `STAGES`=1: a=0x000, b=0x000, cin=1 → `OUTS`=0x0001. Then a=0xFFF, b=0xFFF, cin=1 → `OUTS`=0x1FFF.
- `WIDTH`=13, `STAGES`=4: random stream of 10k beats against a reference a+b+cin, with `out_ready` randomly toggled at 50% → all results match, in order, none lost or duplicated. `in_ready`=0 whenever 4 beats are held and `out_ready`=0.
- Back-pressure hold: `STAGES`=3, `out_ready`=0 for 5 cycles after the first result → `OUTS` and `out_valid` are stable throughout. On the release cycle a new beat is accepted in the same cycle.
- Reset mid-stream: assert `rst` with 3 beats in flight → `out_valid`=0 and `OUTS`=0 immediately, with no stale result after release.
- With `BK_ADDER_OVERFLOW_EN`, `WIDTH`=12: a=0x7FF, b=0x001 → `ovf`=1. Then a=0x800, b=0x800 → `ovf`=1, `OUTS`=0x1000. Then a=0x7FF, b=0x800 → `ovf`=0.

Source files
------------

// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: pipelined Brent-Kung prefix adder with valid/ready on both sides.
// Define BK_ADDER_OVERFLOW_EN to add the registered signed-overflow output ovf.
module bk_adder_pipe #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] INPUTS,
  input  logic               cin,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH:0]     OUTS,
  output logic               out_valid,
  input  logic               out_ready
`ifdef BK_ADDER_OVERFLOW_EN
  ,
  output logic               ovf
`endif
);
  localparam int L      = $clog2(WIDTH + 1);
  localparam int P      = 1 << L;
  localparam int DW     = WIDTH + 2 * P;
  localparam int IB     = (STAGES >= 3) ? 1 : 0;
  localparam int I_LAST = STAGES - 1;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "bk_adder_pipe: WIDTH must be 2..64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $fatal(1, "bk_adder_pipe: STAGES must be 1..4");
  end

  // Payload between levels: {original p of each bit, prefix p, prefix g}.
  // Position 0 carries cin as g[-1]; bit i lives at position i+1.
  function automatic logic [DW-1:0] f_l0(input logic [2*WIDTH-1:0] ops, input logic c);
    logic [P-1:0]     g;
    logic [P-1:0]     p;
    logic [WIDTH-1:0] pb;
    g    = '0;
    p    = '0;
    pb   = '0;
    g[0] = c;
    for (int i = 0; i < WIDTH; i++) begin
      g[i+1] = ops[2*i] & ops[2*i+1];
      p[i+1] = ops[2*i] ^ ops[2*i+1];
      pb[i]  = p[i+1];
    end
    return {pb, p, g};
  endfunction

  function automatic logic [DW-1:0] f_up(input logic [DW-1:0] d);
    logic [P-1:0] g;
    logic [P-1:0] p;
    g = d[P-1:0];
    p = d[2*P-1:P];
    for (int l = 0; l < L; l++) begin
      for (int j = 0; j < P; j++) begin
        if (((j + 1) % (1 << (l + 1))) == 0) begin
          g[j] = g[j] | (p[j] & g[j-(1<<l)]);
          p[j] = p[j] & p[j-(1<<l)];
        end
      end
    end
    return {d[DW-1:2*P], p, g};
  endfunction

  function automatic logic [DW-1:0] f_dn(input logic [DW-1:0] d);
    logic [P-1:0] g;
    logic [P-1:0] p;
    g = d[P-1:0];
    p = d[2*P-1:P];
    for (int l = L - 2; l >= 0; l--) begin
      for (int j = 0; j < P; j++) begin
        if ((((j + 1) % (1 << (l + 1))) == (1 << l)) && (j >= 3 * (1 << l) - 1)) begin
          g[j] = g[j] | (p[j] & g[j-(1<<l)]);
          p[j] = p[j] & p[j-(1<<l)];
        end
      end
    end
    return {d[DW-1:2*P], p, g};
  endfunction

  // g[i] is now the carry into bit i; g[WIDTH] is the carry-out.
  function automatic logic [WIDTH:0] f_l3(input logic [DW-1:0] d);
    logic [P-1:0]     g;
    logic [WIDTH-1:0] pb;
    g  = d[P-1:0];
    pb = d[DW-1:2*P];
    return {g[WIDTH], pb ^ g[WIDTH-1:0]};
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_ld;
  logic [STAGES:0]   w_vup;
  logic              w_ld_run;

  assign w_vup = {r_vld, in_valid};

  // A stage loads when empty or when everything downstream of it can move.
  always_comb begin
    w_ld             = '0;
    w_ld_run         = out_ready | ~r_vld[STAGES-1];
    w_ld[STAGES-1]   = w_ld_run;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_ld_run = ~r_vld[k] | w_ld_run;
      w_ld[k]  = w_ld_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ld[k]) r_vld[k] <= w_vup[k];
      end
    end
  end

  assign in_ready  = w_ld[0] & ~rst;
  assign out_valid = r_vld[I_LAST];

  logic [DW-1:0]  w_l0, w_s1, w_l1, w_s2, w_l2, w_s3;
  logic [WIDTH:0] w_l3;
  logic [WIDTH:0] r_outs;

  assign w_l0 = f_l0(INPUTS, cin);

  if (STAGES >= 3) begin : g_reg_l0
    logic [DW-1:0] r_l0;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_l0 <= '0;
      else if (w_ld[0] && in_valid) r_l0 <= w_l0;
    end
    assign w_s1 = r_l0;
  end else begin : g_pass_l0
    assign w_s1 = w_l0;
  end

  assign w_l1 = f_up(w_s1);

  if (STAGES >= 2) begin : g_reg_l1
    logic [DW-1:0] r_l1;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_l1 <= '0;
      else if (w_ld[IB] && w_vup[IB]) r_l1 <= w_l1;
    end
    assign w_s2 = r_l1;
  end else begin : g_pass_l1
    assign w_s2 = w_l1;
  end

  assign w_l2 = f_dn(w_s2);

  if (STAGES >= 4) begin : g_reg_l2
    logic [DW-1:0] r_l2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_l2 <= '0;
      else if (w_ld[2] && w_vup[2]) r_l2 <= w_l2;
    end
    assign w_s3 = r_l2;
  end else begin : g_pass_l2
    assign w_s3 = w_l2;
  end

  assign w_l3 = f_l3(w_s3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_outs <= '0;
    else if (w_ld[I_LAST] && w_vup[I_LAST]) r_outs <= w_l3;
  end

  assign OUTS = r_outs;

`ifdef BK_ADDER_OVERFLOW_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_ld[I_LAST] && w_vup[I_LAST]) r_ovf <= w_s3[WIDTH-1] ^ w_s3[WIDTH];
  end
  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_bk_adder_pipe.sv
// tb_bk_adder_pipe: directed and random checks of bk_adder_pipe (WIDTH=12, STAGES=4)
// against an arithmetic reference model with an in-order scoreboard.
module tb_bk_adder_pipe;
  localparam int W  = 12;
  localparam int S  = 4;
  localparam int IW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] INPUTS;
  logic          cin;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    OUTS;
  logic          out_valid;
  logic          out_ready;
`ifdef BK_ADDER_OVERFLOW_EN
  logic          ovf;
`endif

  int n_err = 0;
  int n_chk = 0;
  logic [W:0] q_sum[$];
  bit         q_ovf[$];

  always #5 clk = ~clk;

  bk_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .INPUTS    (INPUTS),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .OUTS      (OUTS),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef BK_ADDER_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  function automatic logic [IW-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [IW-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  function automatic logic [W:0] ref_sum(input logic [IW-1:0] ops, input logic c);
    logic [W-1:0] a, b;
    for (int i = 0; i < W; i++) begin
      a[i] = ops[2*i];
      b[i] = ops[2*i+1];
    end
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Signed overflow: operands share a sign and the result sign differs.
  function automatic bit ref_ovf(input logic [IW-1:0] ops, input logic c);
    logic [W:0] s;
    logic       sa, sb;
    s  = ref_sum(ops, c);
    sa = ops[2*(W-1)];
    sb = ops[2*(W-1)+1];
    return (sa == sb) && (s[W-1] != sa);
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int cnt;
    if (rst) begin
      q_sum.delete();
      q_ovf.delete();
      chk(!out_valid && OUTS == '0 && !in_ready, "reset_outputs",
          {out_valid, in_ready, OUTS}, 64'd0);
    end else begin
      cnt = q_sum.size();
      chk(in_ready == ((cnt < S) || out_ready), "in_ready", in_ready, ((cnt < S) || out_ready));
      if (out_valid) begin
        chk(cnt != 0, "result_present", cnt, 1);
        if (cnt != 0) begin
          chk(OUTS == q_sum[0], "result", OUTS, q_sum[0]);
`ifdef BK_ADDER_OVERFLOW_EN
          chk(ovf == q_ovf[0], "ovf", ovf, q_ovf[0]);
`endif
          if (out_ready) begin
            void'(q_sum.pop_front());
            void'(q_ovf.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        q_sum.push_back(ref_sum(INPUTS, cin));
        q_ovf.push_back(ref_ovf(INPUTS, cin));
      end
    end
  end

  // Called shortly after a rising edge; returns shortly after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output bit ok);
    bit acc;
    int n;
    INPUTS   = pack(a, b);
    cin      = c;
    in_valid = 1'b1;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    ok       = acc;
  endtask

  task automatic check_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic [W:0] exp_outs, input bit exp_ovf);
    bit ok;
    int lat;
    out_ready = 1'b1;
    send(a, b, c, ok);
    chk(ok, "accept", ok, 1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(lat == S, "latency", lat, S);
    chk(OUTS == exp_outs, "literal_outs", OUTS, exp_outs);
`ifdef BK_ADDER_OVERFLOW_EN
    chk(ovf == exp_ovf, "literal_ovf", ovf, exp_ovf);
`else
    if (exp_ovf) n_chk = n_chk + 0;
`endif
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = 0;
    while ((q_sum.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(q_sum.size() == 0 && !out_valid, "drain", q_sum.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] held;
    bit         ok;
    int         n;
    rst       = 1'b1;
    INPUTS    = '0;
    cin       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk(in_ready == 1'b1, "ready_after_reset", in_ready, 1);
    chk(!out_valid && OUTS == '0, "idle_after_reset", {out_valid, OUTS}, 0);

    check_one(12'hFFF, 12'h001, 1'b0, 13'h1000, 1'b0);
    check_one(12'h000, 12'h000, 1'b1, 13'h0001, 1'b0);
    check_one(12'hFFF, 12'hFFF, 1'b1, 13'h1FFF, 1'b0);
    check_one(12'hFFF, 12'h000, 1'b1, 13'h1000, 1'b0);
    check_one(12'h7FF, 12'h001, 1'b0, 13'h0800, 1'b1);
    check_one(12'h800, 12'h800, 1'b0, 13'h1000, 1'b1);
    check_one(12'h7FF, 12'h800, 1'b0, 13'h0FFF, 1'b0);
    check_one(12'hA5C, 12'h3B7, 1'b1, 13'h0E14, 1'b0);
    drain();

    // Back-pressure: hold the first result for 5 cycles while the pipe fills.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n         = 0;
    while (!out_valid && n < 20) begin
      INPUTS = IW'($urandom);
      cin    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    chk(out_valid, "bp_first_result", out_valid, 1);
    held = OUTS;
    repeat (5) begin
      INPUTS = IW'($urandom);
      @(posedge clk);
      #1;
      chk(out_valid && OUTS == held, "bp_hold", {out_valid, OUTS}, {1'b1, held});
    end
    chk(!in_ready, "bp_full_stall", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk(in_ready, "bp_release_accept", in_ready, 1);
    @(posedge clk);
    #1;
    drain();

    // Reset with three beats in flight, one already showing at the output.
    out_ready = 1'b0;
    send(12'h123, 12'h456, 1'b0, ok);
    send(12'h0F0, 12'h0F0, 1'b1, ok);
    send(12'hFFF, 12'h800, 1'b0, ok);
    chk(ok, "mid_accept", ok, 1);
    @(posedge clk);
    #1;
    chk(out_valid && OUTS == 13'h0579, "pre_reset_result", OUTS, 13'h0579);
    #2;
    rst = 1'b1;
    #1;
    chk(!out_valid && OUTS == '0 && !in_ready, "reset_midstream", {out_valid, in_ready, OUTS}, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk(!out_valid, "no_stale_after_reset", out_valid, 0);
    end

    // Random stream with 50% in_valid and 50% out_ready.
    repeat (3000) begin
      INPUTS    = IW'($urandom);
      cin       = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
